// File: rtl/uart_tx_queue.sv
// Byte FIFO in front of a UART transmitter, drained by an IDLE/ARMED/BUSY dispatcher.
// Optional feature: define UART_TXQ_COUNT_EN to add the 16-bit sent_count output.
`timescale 1ns/1ps

module uart_tx_queue #(
    parameter int unsigned DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_valid,
    input  logic [7:0]            wr_data,
    output logic                  wr_ready,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  empty,
    output logic                  overflow,
    output logic                  uart_transmit,
    output logic [7:0]            uart_tx_byte,
    input  logic                  uart_busy
`ifdef UART_TXQ_COUNT_EN
    ,
    output logic [15:0]           sent_count
`endif
);

    localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;
    localparam int unsigned LW    = DEPTH_LOG2 + 1;
    localparam int unsigned PW    = DEPTH_LOG2;

    typedef enum logic [1:0] {IDLE, ARMED, BUSY} state_t;

    state_t          state;
    state_t          state_next;
    logic [7:0]      mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic            head_valid;
    logic            armed_wait;
    logic            push_c;
    logic            pop_c;

    // Flags come straight from the pre-edge occupancy, so a same-cycle pop never frees a slot.
    assign empty    = (level == LW'(0));
    assign wr_ready = (level != LW'(DEPTH));
    assign push_c   = wr_valid && wr_ready;

    // head_valid trails empty by one cycle: a byte must sit in the FIFO a full cycle before issue.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_valid <= 1'b0;
        end else begin
            head_valid <= !empty;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (pop_c) begin
                    state_next = ARMED;
                end
            end
            ARMED: begin
                if (uart_busy) begin
                    state_next = BUSY;
                end else if (armed_wait) begin
                    state_next = IDLE;
                end
            end
            BUSY: begin
                if (!uart_busy) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        pop_c = 1'b0;
        if ((state == IDLE) && head_valid && !empty && !uart_busy) begin
            pop_c = 1'b1;
        end
    end

    // Marks the first quiet ARMED cycle; a second quiet cycle gives up on the UART and returns to IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            armed_wait <= 1'b0;
        end else begin
            armed_wait <= (state == ARMED) && !uart_busy;
        end
    end

    always_ff @(posedge clk) begin
        if (push_c && !rst) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr        <= PW'(0);
            rd_ptr        <= PW'(0);
            level         <= LW'(0);
            overflow      <= 1'b0;
            uart_transmit <= 1'b0;
            uart_tx_byte  <= 8'h00;
        end else begin
            uart_transmit <= pop_c;
            if (push_c) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop_c) begin
                uart_tx_byte <= mem[rd_ptr];
                rd_ptr       <= rd_ptr + PW'(1);
            end
            if (wr_valid && !wr_ready) begin
                overflow <= 1'b1;
            end
            case ({push_c, pop_c})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

`ifdef UART_TXQ_COUNT_EN
    // Counts issued start pulses; advances on the edge that raises uart_transmit.
    always_ff @(posedge clk) begin
        if (rst) begin
            sent_count <= 16'h0000;
        end else if (pop_c) begin
            sent_count <= sent_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_uart_tx_queue.sv
// Self-checking bench for uart_tx_queue: queue-based occupancy/order model plus a busy-line UART model.
`timescale 1ns/1ps

module tb_uart_tx_queue;

    localparam int unsigned DEPTH_LOG2 = 4;
    localparam int unsigned DEPTH      = 16;
    localparam int unsigned LW         = DEPTH_LOG2 + 1;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            wr_valid = 1'b0;
    logic [7:0]      wr_data = 8'h00;
    logic            wr_ready;
    logic [LW-1:0]   level;
    logic            empty;
    logic            overflow;
    logic            uart_transmit;
    logic [7:0]      uart_tx_byte;
    logic            uart_busy;
`ifdef UART_TXQ_COUNT_EN
    logic [15:0]     sent_count;
`endif

    logic busy_drv = 1'b0;
    logic busy_mdl = 1'b0;
    logic mdl_en   = 1'b0;
    assign uart_busy = mdl_en ? busy_mdl : busy_drv;

    int checks = 0;
    int errors = 0;

    // Reference model state
    byte unsigned mq[$];
    bit           m_over = 1'b0;
    int           cyc = 0;
    int           npulses = 0;
    int           pulse_cyc[$];
    byte unsigned pulse_byte[$];

    logic        mon_wv;
    logic        mon_rst;
    logic [7:0]  mon_wd;
    bit          mon_acc;
    byte unsigned mon_exp;

    int mdl_cnt = 0;
    bit mdl_pend = 1'b0;

    uart_tx_queue #(.DEPTH_LOG2(DEPTH_LOG2)) dut (
        .clk           (clk),
        .rst           (rst),
        .wr_valid      (wr_valid),
        .wr_data       (wr_data),
        .wr_ready      (wr_ready),
        .level         (level),
        .empty         (empty),
        .overflow      (overflow),
        .uart_transmit (uart_transmit),
        .uart_tx_byte  (uart_tx_byte),
        .uart_busy     (uart_busy)
`ifdef UART_TXQ_COUNT_EN
        ,
        .sent_count    (sent_count)
`endif
    );

    always #5 clk = ~clk;

    // Scoreboard: capture pre-edge inputs, then apply accept/drop/issue rules to the byte queue.
    always begin
        @(posedge clk);
        mon_wv  = wr_valid;
        mon_wd  = wr_data;
        mon_rst = rst;
        #1;
        cyc++;
        if (mon_rst) begin
            mq.delete();
            m_over = 1'b0;
        end else begin
            mon_acc = mon_wv && (mq.size() < DEPTH);
            if (uart_transmit === 1'b1) begin
                npulses++;
                pulse_cyc.push_back(cyc);
                pulse_byte.push_back(uart_tx_byte);
                checks++;
                if (mq.size() == 0) begin
                    errors++;
                    $display("FAIL pulse_source: got pulse with byte %02h want no pulse (model queue empty)", uart_tx_byte);
                end else begin
                    mon_exp = mq.pop_front();
                    if (uart_tx_byte !== mon_exp) begin
                        errors++;
                        $display("FAIL byte_order: got %02h want %02h", uart_tx_byte, mon_exp);
                    end
                end
            end
            if (mon_acc) mq.push_back(mon_wd);
            if (mon_wv && !mon_acc) m_over = 1'b1;
        end
    end

    // UART model: busy rises one cycle after a start pulse and stays up for 40 cycles.
    always begin
        @(posedge clk);
        #1;
        if (!mdl_en) begin
            busy_mdl = 1'b0;
            mdl_cnt  = 0;
            mdl_pend = 1'b0;
        end else begin
            if (mdl_cnt > 0) begin
                mdl_cnt--;
                if (mdl_cnt == 0) busy_mdl = 1'b0;
            end
            if (mdl_pend) begin
                busy_mdl = 1'b1;
                mdl_cnt  = 40;
                mdl_pend = 1'b0;
            end
            if (uart_transmit === 1'b1) mdl_pend = 1'b1;
        end
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        wr_valid = 1'b0;
        busy_drv = 1'b0;
        step(3);
        checks++; if (level !== LW'(0)) begin errors++; $display("FAIL reset_level: got %0d want 0", level); end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b want 1", empty); end
        checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL reset_wr_ready: got %b want 1", wr_ready); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b want 0", overflow); end
        checks++; if (uart_transmit !== 1'b0) begin errors++; $display("FAIL reset_transmit: got %b want 0", uart_transmit); end
        checks++; if (uart_tx_byte !== 8'h00) begin errors++; $display("FAIL reset_tx_byte: got %02h want 00", uart_tx_byte); end
        rst = 1'b0;
        step(2);
    endtask

    task automatic test_single();
        busy_drv = 1'b0;
        wr_data  = 8'h41;
        wr_valid = 1'b1;
        step();
        wr_valid = 1'b0;
        checks++; if (level !== LW'(1)) begin errors++; $display("FAIL single_level: got %0d want 1", level); end
        checks++; if (uart_transmit !== 1'b0) begin errors++; $display("FAIL single_no_bypass_n: got %b want 0", uart_transmit); end
        step();
        checks++; if (uart_transmit !== 1'b0) begin errors++; $display("FAIL single_no_bypass_n1: got %b want 0", uart_transmit); end
        step();
        checks++; if (uart_transmit !== 1'b1) begin errors++; $display("FAIL single_pulse_n2: got %b want 1", uart_transmit); end
        checks++; if (uart_tx_byte !== 8'h41) begin errors++; $display("FAIL single_byte: got %02h want 41", uart_tx_byte); end
        step();
        checks++; if (uart_transmit !== 1'b0) begin errors++; $display("FAIL single_one_cycle: got %b want 0", uart_transmit); end
        checks++; if (uart_tx_byte !== 8'h41) begin errors++; $display("FAIL single_byte_held: got %02h want 41", uart_tx_byte); end
        step(4);
    endtask

    task automatic test_overflow();
        int n0;
        int first;
        busy_drv = 1'b1;
        for (int i = 0; i < 17; i++) begin
            wr_data  = 8'(i);
            wr_valid = 1'b1;
            step();
            if (i == 15) begin
                checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_early: got %b want 0", overflow); end
            end
        end
        wr_valid = 1'b0;
        checks++; if (level !== LW'(16)) begin errors++; $display("FAIL ovf_level: got %0d want 16", level); end
        checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL ovf_wr_ready: got %b want 0", wr_ready); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b want 1", overflow); end
        n0    = npulses;
        first = pulse_byte.size();
        // Release the UART and offer a byte on the very edge the head pops: it must be dropped.
        busy_drv = 1'b0;
        wr_data  = 8'hEE;
        wr_valid = 1'b1;
        step();
        wr_valid = 1'b0;
        checks++; if (level !== LW'(15)) begin errors++; $display("FAIL ovf_pop_write_level: got %0d want 15", level); end
        for (int t = 0; t < 300 && (npulses - n0) < 16; t++) step();
        step(6);
        checks++; if ((npulses - n0) != 16) begin errors++; $display("FAIL ovf_pulse_count: got %0d want 16", npulses - n0); end
        for (int k = 0; k < 16 && (first + k) < pulse_byte.size(); k++) begin
            checks++;
            if (pulse_byte[first + k] !== 8'(k)) begin
                errors++;
                $display("FAIL ovf_order[%0d]: got %02h want %02h", k, pulse_byte[first + k], 8'(k));
            end
        end
        checks++; if (level !== LW'(0)) begin errors++; $display("FAIL ovf_drain_level: got %0d want 0", level); end
    endtask

    task automatic test_stream();
        int n0;
        int w0;
        mdl_en = 1'b1;
        n0 = npulses;
        for (int i = 0; i < 3; i++) begin
            wr_data  = 8'($urandom);
            wr_valid = 1'b1;
            step();
            if (i == 0) w0 = cyc;
        end
        wr_valid = 1'b0;
        for (int t = 0; t < 400 && (npulses - n0) < 3; t++) step();
        checks++; if ((npulses - n0) != 3) begin errors++; $display("FAIL stream_count: got %0d want 3", npulses - n0); end
        if ((npulses - n0) >= 3) begin
            checks++;
            if (pulse_cyc[n0] != w0 + 2) begin errors++; $display("FAIL stream_first: got edge %0d want %0d", pulse_cyc[n0], w0 + 2); end
            // busy is seen low on edge P+42; the next pulse belongs on the edge after (BUSY->IDLE->ARMED).
            for (int k = 1; k < 3; k++) begin
                checks++;
                if (pulse_cyc[n0 + k] - pulse_cyc[n0 + k - 1] != 43) begin
                    errors++;
                    $display("FAIL stream_gap[%0d]: got %0d want 43", k, pulse_cyc[n0 + k] - pulse_cyc[n0 + k - 1]);
                end
            end
        end
        step(45);
        mdl_en = 1'b0;
        step(3);
    endtask

    task automatic test_timeout();
        int n0;
        int w0;
        busy_drv = 1'b0;
        n0 = npulses;
        for (int i = 0; i < 2; i++) begin
            wr_data  = 8'($urandom);
            wr_valid = 1'b1;
            step();
            if (i == 0) w0 = cyc;
        end
        wr_valid = 1'b0;
        for (int t = 0; t < 100 && (npulses - n0) < 2; t++) step();
        checks++; if ((npulses - n0) != 2) begin errors++; $display("FAIL timeout_count: got %0d want 2", npulses - n0); end
        if ((npulses - n0) >= 2) begin
            checks++;
            if (pulse_cyc[n0] != w0 + 2) begin errors++; $display("FAIL timeout_first: got edge %0d want %0d", pulse_cyc[n0], w0 + 2); end
            checks++;
            if (pulse_cyc[n0 + 1] - pulse_cyc[n0] != 3) begin
                errors++;
                $display("FAIL timeout_gap: got %0d want 3", pulse_cyc[n0 + 1] - pulse_cyc[n0]);
            end
        end
        step(4);
        checks++; if (level !== LW'(0)) begin errors++; $display("FAIL timeout_level: got %0d want 0", level); end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL timeout_empty: got %b want 1", empty); end
    endtask

    task automatic test_reset_busy();
        int n0;
        int p0;
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL sticky_overflow: got %b want 1", overflow); end
        mdl_en = 1'b1;
        n0 = npulses;
        for (int i = 0; i < 6; i++) begin
            wr_data  = 8'($urandom);
            wr_valid = 1'b1;
            step();
        end
        wr_valid = 1'b0;
        checks++; if (level !== LW'(5)) begin errors++; $display("FAIL rstbusy_level5: got %0d want 5", level); end
        p0 = (npulses > n0) ? pulse_cyc[n0] : 0;
        rst      = 1'b1;
        wr_data  = 8'h77;
        wr_valid = 1'b1;
        step();
        checks++; if (level !== LW'(0)) begin errors++; $display("FAIL rstbusy_level: got %0d want 0", level); end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL rstbusy_empty: got %b want 1", empty); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL rstbusy_overflow: got %b want 0", overflow); end
        checks++; if (uart_transmit !== 1'b0) begin errors++; $display("FAIL rstbusy_transmit: got %b want 0", uart_transmit); end
        checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL rstbusy_wr_ready: got %b want 1", wr_ready); end
        checks++; if (uart_tx_byte !== 8'h00) begin errors++; $display("FAIL rstbusy_tx_byte: got %02h want 00", uart_tx_byte); end
        // An IDLE dispatcher issues on the very edge the still-running UART busy is first seen low.
        rst      = 1'b0;
        wr_data  = 8'h5A;
        wr_valid = 1'b1;
        n0 = npulses;
        step();
        wr_valid = 1'b0;
        for (int t = 0; t < 100 && npulses == n0; t++) step();
        checks++; if (npulses == n0) begin errors++; $display("FAIL rstbusy_pulse: got 0 pulses want 1"); end
        if (npulses > n0) begin
            checks++;
            if (pulse_cyc[n0] != p0 + 42) begin errors++; $display("FAIL rstbusy_idle_edge: got edge %0d want %0d", pulse_cyc[n0], p0 + 42); end
            checks++;
            if (pulse_byte[n0] !== 8'h5A) begin errors++; $display("FAIL rstbusy_byte: got %02h want 5a", pulse_byte[n0]); end
        end
        step(3);
        mdl_en = 1'b0;
        step(4);
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            wr_valid = ($urandom_range(0, 1) == 1);
            wr_data  = 8'($urandom);
            busy_drv = ($urandom_range(0, 3) == 0);
            step();
            checks++; if (level !== LW'(mq.size())) begin errors++; $display("FAIL rand_level: got %0d want %0d", level, mq.size()); end
            checks++; if (empty !== (mq.size() == 0)) begin errors++; $display("FAIL rand_empty: got %b want %b", empty, mq.size() == 0); end
            checks++; if (wr_ready !== (mq.size() < DEPTH)) begin errors++; $display("FAIL rand_wr_ready: got %b want %b", wr_ready, mq.size() < DEPTH); end
            checks++; if (overflow !== m_over) begin errors++; $display("FAIL rand_overflow: got %b want %b", overflow, m_over); end
        end
        wr_valid = 1'b0;
        busy_drv = 1'b0;
        for (int t = 0; t < 200 && mq.size() != 0; t++) step();
        step(4);
        checks++; if (level !== LW'(0)) begin errors++; $display("FAIL rand_drain_level: got %0d want 0", level); end
        checks++; if (mq.size() != 0) begin errors++; $display("FAIL rand_drain_model: got %0d bytes left want 0", mq.size()); end
    endtask

`ifdef UART_TXQ_COUNT_EN
    task automatic test_count();
        int n0;
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        busy_drv = 1'b0;
        n0 = npulses;
        wr_valid = 1'b1;
        for (int t = 0; t < 250000 && (npulses - n0) < 65537; t++) begin
            wr_data = 8'($urandom);
            step();
        end
        wr_valid = 1'b0;
        checks++; if ((npulses - n0) != 65537) begin errors++; $display("FAIL count_pulses: got %0d want 65537", npulses - n0); end
        checks++; if (sent_count !== 16'h0001) begin errors++; $display("FAIL count_wrap: got %04h want 0001", sent_count); end
    endtask
`endif

    initial begin
        #20_000_000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_single();
        test_overflow();
        test_stream();
        test_timeout();
        test_reset_busy();
        test_random();
`ifdef UART_TXQ_COUNT_EN
        test_count();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
